// File: rtl/eggtimer_ctrl_if.sv
// Egg timer controller <-> time_count bus.
// Programmed BCD time, load/decrement strobes and zero flag.
interface eggtimer_ctrl_if;
  logic [3:0] seconds_prog;
  logic [3:0] tens_seconds_prog;
  logic [3:0] minutes_prog;
  logic [3:0] tens_minutes_prog;
  logic       load;
  logic       dec_en;
  logic       count_zero;

  modport master (
    output seconds_prog,
    output tens_seconds_prog,
    output minutes_prog,
    output tens_minutes_prog,
    output load,
    output dec_en,
    input  count_zero
  );

  modport slave (
    input  seconds_prog,
    input  tens_seconds_prog,
    input  minutes_prog,
    input  tens_minutes_prog,
    input  load,
    input  dec_en,
    output count_zero
  );
endinterface

// File: rtl/eggtimer_ctrl.sv
// Egg timer sequencer: BCD time programming and PROG/RUN/PAUSE/ALARM FSM.
// All outputs are registered from next-state/next-value logic.
module eggtimer_ctrl #(
  parameter int ALARM_SECONDS = 30,
  parameter int ALM_CTR_WIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_1s,
  input  logic start_stop,
  input  logic clear,
  input  logic inc_sec,
  input  logic inc_min,
  eggtimer_ctrl_if.master tc,
  output logic display_prog,
  output logic alarm,
  output logic timer_enabled_led,
  output logic timer_on_led
);

  typedef enum logic [1:0] {
    PROG  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [ALM_CTR_WIDTH-1:0] LAST =
    ALM_CTR_WIDTH'(ALARM_SECONDS - 1);
  localparam logic [ALM_CTR_WIDTH-1:0] ONE =
    ALM_CTR_WIDTH'(1);

  state_t state_q, state_d;

  logic [3:0] s_q, ts_q, m_q, tm_q;
  logic [3:0] s_d, ts_d, m_d, tm_d;
  logic       load_q, load_d;
  logic       dec_q, dec_d;
  logic       alarm_q, alarm_d;
  logic [ALM_CTR_WIDTH-1:0] cnt_q, cnt_d;

  logic prog_zero;
  logic last_tick;

  assign prog_zero = (s_q == 4'd0) && (ts_q == 4'd0) &&
                     (m_q == 4'd0) && (tm_q == 4'd0);
  assign last_tick = pulse_1s && (cnt_q == LAST);

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= PROG;
      s_q               <= 4'd0;
      ts_q              <= 4'd0;
      m_q               <= 4'd0;
      tm_q              <= 4'd0;
      load_q            <= 1'b0;
      dec_q             <= 1'b0;
      alarm_q           <= 1'b0;
      cnt_q             <= '0;
      display_prog      <= 1'b1;
      timer_enabled_led <= 1'b0;
      timer_on_led      <= 1'b0;
    end else begin
      state_q           <= state_d;
      s_q               <= s_d;
      ts_q              <= ts_d;
      m_q               <= m_d;
      tm_q              <= tm_d;
      load_q            <= load_d;
      dec_q             <= dec_d;
      alarm_q           <= alarm_d;
      cnt_q             <= cnt_d;
      display_prog      <= (state_d == PROG);
      timer_enabled_led <= (state_d != PROG);
      timer_on_led      <= (state_d == RUN);
    end
  end

  // Next state: clear > expiry > start_stop > tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PROG: begin
        if (!clear && start_stop && !prog_zero)
          state_d = RUN;
      end
      RUN: begin
        if (clear)
          state_d = PROG;
        else if (tc.count_zero && !load_q)
          state_d = ALARM;
        else if (start_stop)
          state_d = PAUSE;
      end
      PAUSE: begin
        if (clear)
          state_d = PROG;
        else if (start_stop)
          state_d = RUN;
      end
      ALARM: begin
        if (clear || start_stop || last_tick)
          state_d = PROG;
      end
      default: state_d = PROG;
    endcase
  end

  // Next values of registered outputs
  always_comb begin
    s_d  = s_q;
    ts_d = ts_q;
    m_d  = m_q;
    tm_d = tm_q;
    if (state_q == PROG) begin
      if (clear) begin
        s_d  = 4'd0;
        ts_d = 4'd0;
        m_d  = 4'd0;
        tm_d = 4'd0;
      end else begin
        if (inc_sec) begin
          if (s_q == 4'd9) begin
            s_d  = 4'd0;
            ts_d = (ts_q == 4'd5) ? 4'd0 : ts_q + 4'd1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
        if (inc_min) begin
          if (m_q == 4'd9) begin
            m_d  = 4'd0;
            tm_d = (tm_q == 4'd9) ? 4'd0 : tm_q + 4'd1;
          end else begin
            m_d = m_q + 4'd1;
          end
        end
      end
    end

    load_d = (state_q == PROG) && (state_d == RUN);
    dec_d  = (state_q == RUN) && (state_d == RUN) && pulse_1s;

    alarm_d = 1'b0;
    cnt_d   = '0;
    if (state_d == ALARM && state_q != ALARM) begin
      alarm_d = 1'b1;
    end else if (state_d == ALARM) begin
      alarm_d = pulse_1s ? ~alarm_q : alarm_q;
      cnt_d   = pulse_1s ? cnt_q + ONE : cnt_q;
    end
  end

  assign tc.seconds_prog      = s_q;
  assign tc.tens_seconds_prog = ts_q;
  assign tc.minutes_prog      = m_q;
  assign tc.tens_minutes_prog = tm_q;
  assign tc.load              = load_q;
  assign tc.dec_en            = dec_q;
  assign alarm                = alarm_q;

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Directed table-driven bench for eggtimer_ctrl.
// A small time_count stub closes the count_zero loop for the expiry test.
module tb_eggtimer_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pulse_1s = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic inc_sec = 1'b0;
  logic inc_min = 1'b0;
  logic display_prog, alarm, timer_enabled_led, timer_on_led;

  logic cz_drv = 1'b0;
  logic use_stub = 1'b0;
  int   stub = 0;

  int n_cmp = 0;
  int n_bad = 0;

  eggtimer_ctrl_if tc ();

  eggtimer_ctrl #(
    .ALARM_SECONDS(4),
    .ALM_CTR_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pulse_1s(pulse_1s),
    .start_stop(start_stop),
    .clear(clear),
    .inc_sec(inc_sec),
    .inc_min(inc_min),
    .tc(tc.master),
    .display_prog(display_prog),
    .alarm(alarm),
    .timer_enabled_led(timer_enabled_led),
    .timer_on_led(timer_on_led)
  );

  always #5 clk = ~clk;

  // time_count stand-in
  always @(posedge clk) begin
    if (tc.load)
      stub <= (int'(tc.tens_minutes_prog) * 10 + int'(tc.minutes_prog)) * 60
            + int'(tc.tens_seconds_prog) * 10 + int'(tc.seconds_prog);
    else if (tc.dec_en && stub != 0)
      stub <= stub - 1;
  end

  assign tc.count_zero = use_stub ? (stub == 0) : cz_drv;

  typedef struct {
    logic        ss, clr, is, im, p1, cz;
    logic [5:0]  flags;
    logic [15:0] prog;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] flags_now();
    return {display_prog, timer_enabled_led, timer_on_led,
            tc.load, tc.dec_en, alarm};
  endfunction

  function automatic logic [15:0] prog_now();
    return {tc.tens_minutes_prog, tc.minutes_prog,
            tc.tens_seconds_prog, tc.seconds_prog};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic ss, input logic clr, input logic is,
                       input logic im, input logic p1, input logic cz);
    start_stop = ss;
    clear      = clr;
    inc_sec    = is;
    inc_min    = im;
    pulse_1s   = p1;
    cz_drv     = cz;
    cyc();
    start_stop = 1'b0;
    clear      = 1'b0;
    inc_sec    = 1'b0;
    inc_min    = 1'b0;
    pulse_1s   = 1'b0;
    cz_drv     = 1'b0;
  endtask

  // flags: display_prog, enabled_led, on_led, load, dec_en, alarm
  task automatic add(input logic ss, input logic clr, input logic is,
                     input logic im, input logic p1, input logic cz,
                     input logic [5:0] f, input logic [15:0] p);
    vec_t v;
    v.ss = ss; v.clr = clr; v.is = is; v.im = im; v.p1 = p1; v.cz = cz;
    v.flags = f;
    v.prog  = p;
    tbl.push_back(v);
  endtask

  initial begin
    int waited;

    add(1,0,0,0,0,0, 6'b100000, 16'h0000);
    add(0,0,1,1,0,0, 6'b100000, 16'h0101);
    add(0,0,1,0,0,0, 6'b100000, 16'h0102);
    add(0,1,0,0,0,0, 6'b100000, 16'h0000);
    add(0,0,1,0,0,0, 6'b100000, 16'h0001);
    add(0,0,1,0,0,0, 6'b100000, 16'h0002);
    add(1,0,0,0,0,0, 6'b011100, 16'h0002);
    add(0,0,0,0,1,1, 6'b011010, 16'h0002);
    add(0,0,0,0,0,0, 6'b011000, 16'h0002);
    add(1,0,0,0,0,0, 6'b010000, 16'h0002);
    for (int k = 0; k < 5; k++)
      add(0,0,1,1,1,0, 6'b010000, 16'h0002);
    add(1,0,0,0,0,0, 6'b011000, 16'h0002);
    add(0,0,0,0,1,0, 6'b011010, 16'h0002);
    add(1,0,0,0,0,1, 6'b010001, 16'h0002);
    add(0,0,0,0,1,0, 6'b010000, 16'h0002);
    add(0,0,0,0,1,0, 6'b010001, 16'h0002);
    add(0,0,0,0,0,0, 6'b010001, 16'h0002);
    add(1,0,0,0,0,0, 6'b100000, 16'h0002);
    add(1,0,0,0,0,0, 6'b011100, 16'h0002);
    add(0,0,0,0,0,0, 6'b011000, 16'h0002);
    add(0,1,0,0,0,1, 6'b100000, 16'h0002);

    // reset state
    cyc();
    cyc();
    check("reset_flags", 32'(flags_now()), 32'h20);
    check("reset_prog", 32'(prog_now()), 32'h0);
    #3 reset = 1'b1;
    cyc();

    // seconds wrap without carry, minutes wrap
    for (int k = 0; k < 59; k++) apply(0,0,1,0,0,0);
    check("sec59", 32'(prog_now()), 32'h0059);
    apply(0,0,1,0,0,0);
    check("sec60_wrap", 32'(prog_now()), 32'h0000);
    apply(0,0,1,0,0,0);
    check("sec61", 32'(prog_now()), 32'h0001);
    for (int k = 0; k < 99; k++) apply(0,0,0,1,0,0);
    check("min99", 32'(prog_now()), 32'h9901);
    apply(0,0,0,1,0,0);
    check("min100_wrap", 32'(prog_now()), 32'h0001);
    apply(0,1,0,0,0,0);
    check("prog_clear", 32'(prog_now()), 32'h0000);

    foreach (tbl[i]) begin
      apply(tbl[i].ss, tbl[i].clr, tbl[i].is, tbl[i].im,
            tbl[i].p1, tbl[i].cz);
      check($sformatf("row%0d_flags", i), 32'(flags_now()),
            32'(tbl[i].flags));
      check($sformatf("row%0d_prog", i), 32'(prog_now()),
            32'(tbl[i].prog));
    end

    // 00:03 run to expiry through the stub counter
    apply(0,1,0,0,0,0);
    for (int k = 0; k < 3; k++) apply(0,0,1,0,0,0);
    use_stub = 1'b1;
    apply(1,0,0,0,0,0);
    check("run_load_on", 32'(tc.load), 32'h1);
    apply(0,0,0,0,0,0);
    check("run_load_off", 32'(tc.load), 32'h0);
    for (int k = 0; k < 3; k++) begin
      apply(0,0,0,0,1,0);
      check($sformatf("run_dec%0d", k), 32'(tc.dec_en), 32'h1);
      apply(0,0,0,0,0,0);
    end
    waited = 0;
    while (!alarm && waited < 8) begin
      apply(0,0,0,0,0,0);
      waited++;
    end
    check("expiry_flags", 32'(flags_now()), 32'h11);
    apply(0,0,0,0,1,0);
    check("alm_t1", 32'(flags_now()), 32'h10);
    apply(0,0,0,0,1,0);
    check("alm_t2", 32'(flags_now()), 32'h11);
    apply(0,0,0,0,1,0);
    check("alm_t3", 32'(flags_now()), 32'h10);
    apply(0,0,0,0,1,0);
    check("alm_timeout", 32'(flags_now()), 32'h20);
    check("alm_keep_prog", 32'(prog_now()), 32'h0003);

    // asynchronous reset in RUN with a dec strobe pending
    apply(1,0,0,0,0,0);
    apply(0,0,0,0,1,0);
    check("pre_reset_dec", 32'(tc.dec_en), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_flags", 32'(flags_now()), 32'h20);
    check("async_prog", 32'(prog_now()), 32'h0);
    cyc();
    #3 reset = 1'b1;
    cyc();
    check("post_reset", 32'(flags_now()), 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
